// File: rtl/usr_ctrl.sv
// Command sequencer for a 4-bit universal shift register: decodes load/shift/rotate
// commands into mode lines, serial inputs and parallel data, one step per cycle.
module usr_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] count,
  input  logic [3:0] data_in,
  input  logic       fill,
  input  logic [3:0] q_in,
  output logic       S1,
  output logic       S0,
  output logic       sin_left,
  output logic       sin_right,
  output logic [3:0] D,
  output logic       busy,
  output logic       done
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b010;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b101;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b110;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [OP_W-1:0]     op_q;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [DATA_W-1:0]   data_q;
  logic                fill_q;
  logic                accept;
  logic [1:0]          mode;

  // Only Q[3] and Q[0] feed back into the serial lines.
  logic unused_q;
  assign unused_q = ^q_in[2:1];

  assign accept = (state == ST_IDLE) && start;

  // State register and command latch; command fields only load on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      cnt_q  <= '0;
      data_q <= '0;
      fill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (accept) begin
        op_q   <= op;
        data_q <= data_in;
        fill_q <= fill;
      end
    end
  end

  // Next-state and output decode from state and latched command.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    mode      = MODE_HOLD;
    D         = '0;
    sin_left  = 1'b0;
    sin_right = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_nxt = count;
          case (op)
            OP_LOAD: state_nxt = ST_LOAD;
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR:
              state_nxt = (count != '0) ? ST_SHIFT : ST_DONE;
            default: state_nxt = ST_DONE;
          endcase
        end
      end

      ST_LOAD: begin
        mode      = MODE_LOAD;
        D         = data_q;
        state_nxt = ST_DONE;
      end

      ST_SHIFT: begin
        // Down-counter saturates at zero; the last step leaves for DONE.
        if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_nxt = ST_DONE;
        case (op_q)
          OP_SHR: begin mode = MODE_RIGHT; sin_right = fill_q;  end
          OP_ROR: begin mode = MODE_RIGHT; sin_right = q_in[0]; end
          OP_ASR: begin mode = MODE_RIGHT; sin_right = q_in[3]; end
          OP_SHL: begin mode = MODE_LEFT;  sin_left  = fill_q;  end
          OP_ROL: begin mode = MODE_LEFT;  sin_left  = q_in[3]; end
          default: state_nxt = ST_DONE;
        endcase
      end

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign S1 = mode[1];
  assign S0 = mode[0];

endmodule

// File: doc/usr_ctrl.md
USR_CTRL -- requirements
Module: usr_ctrl

Interface
REQ-001 SHALL have these ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have these ports: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have these ports: start  in  1  command strobe, sampled only in IDLE.
REQ-004 SHALL have these ports: op  in  3  command code (see REQ-012).
REQ-005 SHALL have these ports: count  in  3  shift/rotate step count, 0..7.
REQ-006 SHALL have these ports: data_in  in  4  parallel word for LOAD.
REQ-007 SHALL have these ports: fill  in  1  serial fill bit for logical shifts.
REQ-008 SHALL have these ports: q_in  in  4  feedback of the controlled shift register's Q.
REQ-009 SHALL have these ports: S1, S0  out  1 each  mode lines to register (00 hold, 01 right, 10 left, 11 load).
REQ-010 SHALL have these ports: sin_left, sin_right  out  1 each  serial inputs to register; D  out  4  parallel data to register.
REQ-011 SHALL have these ports: busy  out  1  command in progress; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL decode op as: 000 NOP, 001 LOAD, 010 SHR (fill), 011 SHL (fill), 100 ROR, 101 ROL, 110 ASR, 111 treated as NOP.
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, with registered state and outputs decoded combinationally from state and latched command.
REQ-014 SHALL, in IDLE with start=1, latch op, count, data_in, fill and go to: LOAD for LOAD; SHIFT for shift ops with count!=0; DONE for NOP/111 or count=0.
REQ-015 SHALL drive {S1,S0}=11 and D=latched data for exactly one cycle in LOAD, then go to DONE.
REQ-016 SHALL remain in SHIFT for exactly latched count cycles, driving {S1,S0}=01 for SHR/ROR/ASR and 10 for SHL/ROL, then go to DONE.
REQ-017 SHALL drive sin_right = fill (SHR), q_in[0] (ROR), q_in[3] (ASR); sin_left = fill (SHL), q_in[3] (ROL); the unused serial line SHALL be 0.
REQ-018 SHALL drive {S1,S0}=00, D=0000, sin_left=sin_right=0 in IDLE and DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL hold busy=1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-021 SHALL ignore start and all command inputs while busy=1; changes to them mid-command SHALL NOT affect the running command.
REQ-022 SHALL use a 3-bit down-counter for remaining steps, with no wrap: decrement to 0 ends SHIFT.
REQ-023 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back throughput: N+2 cycles per shift command, 3 per LOAD).

Reset
REQ-024 SHALL, on rst=1 at a rising edge, enter IDLE, clear latched command and counter, and output S1=S0=0, D=0000, sin_left=sin_right=0, busy=0, done=0.
REQ-025 SHALL treat rst as dominant over start and abort any in-progress command with no done pulse; the register holds its current value from the next cycle.

Verification
REQ-026 SHALL pass: LOAD data_in=1010 -> one cycle of mode 11 with D=1010, Q=1010, done pulse 2 cycles after start edge.
REQ-027 SHALL pass: Q=1010, SHR count=2 fill=1 -> mode 01 for 2 cycles, Q=1101 then 1110, done next cycle.
REQ-028 SHALL pass: Q=1001, ROL count=1 -> Q=0011; Q=1000, ASR count=3 -> 1100, 1110, 1111.
REQ-029 SHALL pass: SHL count=0 or op=000 -> no mode change, Q unchanged, done one cycle after start edge.
REQ-030 SHALL pass: start re-pulsed with different op during SHIFT -> ignored, original result produced; rst during SHIFT count=5 after 2 steps -> IDLE next cycle, busy=0, no done, Q holds 2-step value.
